// File: rtl/div_unit_pkg.sv
// ----------------------------------------------------------------------------
// div_unit_pkg
//
// Shared definitions for the 32-bit iterative divider:
//   - div_state_e          : FSM state encodings (DivFree, DivByZero, DivOn, DivEnd)
//   - DivResultReady/NotReady : levels of ready_o
//   - DivStart/DivStop     : levels of start_i
//   - mag32()              : magnitude of an operand under signed/unsigned mode
// ----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int RegWidth       = 32;
    localparam int DoubleRegWidth = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Two's-complement magnitude in signed mode; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [RegWidth-1:0] mag32(input logic [RegWidth-1:0] v,
                                                  input logic                is_signed);
        return (is_signed && v[RegWidth-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
//
// Iterative 32-bit divider (DIV / DIVU), one restoring radix-2 step per cycle.
// Result format: {remainder (HI), quotient (LO)}.
//
// Ports:
//   clk           in   1  clock, all state changes on rising edge
//   rst           in   1  synchronous active-high reset
//   signed_div_i  in   1  1 = signed, 0 = unsigned (sampled with start_i)
//   opdata1_i     in  32  dividend (sampled with start_i)
//   opdata2_i     in  32  divisor  (sampled with start_i)
//   start_i       in   1  request, held until ready_o is seen
//   annul_i       in   1  flush, aborts the current division
//   result_o      out 64  {remainder, quotient}, registered
//   ready_o       out  1  result valid, registered
//
// Configuration macro:
//   DIV_EARLY_OUT_EN  when defined, requests with |dividend| < |divisor|
//                     skip the iteration and finish with quotient 0 and
//                     remainder = dividend, two cycles after acceptance.
// ----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [RegWidth-1:0]       opdata1_i,
    input  logic [RegWidth-1:0]       opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DoubleRegWidth-1:0] result_o,
    output logic                      ready_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_e                r_state;
    logic [4:0]                r_cnt;
    // [64:32] partial remainder, [31:0] dividend bits shifting out / quotient
    // bits shifting in.
    logic [DoubleRegWidth:0]   r_shift;
    logic [RegWidth-1:0]       r_divisor;
    logic                      r_neg_q;
    logic                      r_neg_r;
`ifdef DIV_EARLY_OUT_EN
    logic                      r_early;
    logic [RegWidth-1:0]       r_early_rem;
`endif

    div_state_e                w_state_n;
    logic [4:0]                w_cnt_n;
    logic [DoubleRegWidth:0]   w_shift_n;
    logic [RegWidth-1:0]       w_divisor_n;
    logic                      w_neg_q_n;
    logic                      w_neg_r_n;
    logic [DoubleRegWidth-1:0] w_result_n;
    logic                      w_ready_n;
`ifdef DIV_EARLY_OUT_EN
    logic                      w_early_n;
    logic [RegWidth-1:0]       w_early_rem_n;
`endif

    // ------------------------------------------------------------------
    // Datapath: operand magnitudes, one restoring step, sign fix-up
    // ------------------------------------------------------------------
    logic [RegWidth-1:0]       w_mag_a;
    logic [RegWidth-1:0]       w_mag_b;
    logic [DoubleRegWidth:0]   w_shifted;
    logic [RegWidth+1:0]       w_trial;
    logic [DoubleRegWidth:0]   w_step;
    logic [RegWidth-1:0]       w_quot;
    logic [RegWidth-1:0]       w_rem;

    assign w_mag_a   = mag32(opdata1_i, signed_div_i);
    assign w_mag_b   = mag32(opdata2_i, signed_div_i);

    assign w_shifted = r_shift << 1;
    // 34-bit trial subtraction: the shifted partial remainder can reach 33
    // bits, so the sign of the difference sits in bit 33.
    assign w_trial   = {1'b0, w_shifted[DoubleRegWidth:RegWidth]} - {2'b00, r_divisor};
    assign w_step    = w_trial[RegWidth+1]
                     ? w_shifted
                     : {w_trial[RegWidth:0], w_shifted[RegWidth-1:1], 1'b1};

    // Fix-up applied to the final step so END already holds the signed result.
    assign w_quot    = r_neg_q ? (~w_step[RegWidth-1:0] + 32'd1) : w_step[RegWidth-1:0];
    assign w_rem     = r_neg_r ? (~w_step[DoubleRegWidth-1:RegWidth] + 32'd1)
                               : w_step[DoubleRegWidth-1:RegWidth];

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_shift_n     = r_shift;
        w_divisor_n   = r_divisor;
        w_neg_q_n     = r_neg_q;
        w_neg_r_n     = r_neg_r;
        w_result_n    = result_o;
        w_ready_n     = ready_o;
`ifdef DIV_EARLY_OUT_EN
        w_early_n     = r_early;
        w_early_rem_n = r_early_rem;
`endif

        unique case (r_state)
            DivFree: begin
                w_ready_n  = DivResultNotReady;
                w_result_n = '0;
                if (start_i == DivStart) begin
                    w_divisor_n = w_mag_b;
                    w_shift_n   = {33'd0, w_mag_a};
                    w_cnt_n     = '0;
                    w_neg_q_n   = signed_div_i && (opdata1_i[RegWidth-1] ^ opdata2_i[RegWidth-1]);
                    w_neg_r_n   = signed_div_i && opdata1_i[RegWidth-1];
`ifdef DIV_EARLY_OUT_EN
                    w_early_n     = 1'b0;
                    w_early_rem_n = opdata1_i;
                    if (opdata2_i == '0) begin
                        w_state_n = DivByZero;
                    end else if (w_mag_a < w_mag_b) begin
                        // Shares the one-cycle ZERO hop so the early result
                        // appears in the same cycle as a divide-by-zero.
                        w_early_n = 1'b1;
                        w_state_n = DivByZero;
                    end else begin
                        w_state_n = DivOn;
                    end
`else
                    w_state_n = (opdata2_i == '0) ? DivByZero : DivOn;
`endif
                end
            end

            DivByZero: begin
                w_state_n  = DivEnd;
                w_ready_n  = DivResultReady;
`ifdef DIV_EARLY_OUT_EN
                w_result_n = r_early ? {r_early_rem, 32'd0} : '0;
`else
                w_result_n = '0;
`endif
            end

            DivOn: begin
                w_shift_n = w_step;
                w_cnt_n   = r_cnt + 5'd1;
                if (r_cnt == 5'd31) begin
                    w_state_n  = DivEnd;
                    w_ready_n  = DivResultReady;
                    w_result_n = {w_rem, w_quot};
                end
            end

            DivEnd: begin
                if (start_i == DivStop) begin
                    w_state_n  = DivFree;
                    w_ready_n  = DivResultNotReady;
                    w_result_n = '0;
                end
            end

            default: begin
                w_state_n = DivFree;
            end
        endcase

        // Flush overrides everything, including a start in the same cycle.
        if (annul_i) begin
            w_state_n  = DivFree;
            w_ready_n  = DivResultNotReady;
            w_result_n = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath registers are small and are cleared too, so a
            // reset mid-division leaves nothing behind.
            r_state     <= DivFree;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_divisor   <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            result_o    <= '0;
            ready_o     <= DivResultNotReady;
`ifdef DIV_EARLY_OUT_EN
            r_early     <= 1'b0;
            r_early_rem <= '0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_shift     <= w_shift_n;
            r_divisor   <= w_divisor_n;
            r_neg_q     <= w_neg_q_n;
            r_neg_r     <= w_neg_r_n;
            result_o    <= w_result_n;
            ready_o     <= w_ready_n;
`ifdef DIV_EARLY_OUT_EN
            r_early     <= w_early_n;
            r_early_rem <= w_early_rem_n;
`endif
        end
    end

endmodule
